// File: rtl/ldm_stm_sequencer.sv
// Block load/store multiple sequencer: walks a register list lowest-first, issues one
// word-aligned memory beat per listed register, then optionally writes back the base.
module ldm_stm_sequencer (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        load,
    input  logic        pre_index,
    input  logic        up,
    input  logic        writeback,
    input  logic [3:0]  base_reg,
    input  logic [31:0] base_value,
    input  logic [15:0] reg_list,
    output logic        busy,
    output logic        done,
    output logic        mem_req,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  rf_read_num,
    input  logic [31:0] rf_read_data,
    output logic        rf_write_en,
    output logic [3:0]  rf_write_num,
    output logic [31:0] rf_write_data
);

    typedef enum logic [1:0] {StIdle, StXfer, StWb, StDone} state_e;

    state_e      state_q, state_d;
    logic        load_q, load_d;
    logic        wb_q, wb_d;
    logic [3:0]  base_reg_q, base_reg_d;
    logic [15:0] mask_q, mask_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] new_base_q, new_base_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_write_q, mem_write_d;

    logic [4:0]  n_regs;
    logic [31:0] four_n;
    logic [31:0] start_addr;
    logic [3:0]  cur_num;
    logic [15:0] mask_next;

    // Population count of the incoming list and the lowest set bit of the remaining mask.
    always_comb begin
        n_regs = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n_regs = n_regs + {4'd0, reg_list[i]};
        end
        cur_num = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (mask_q[i]) begin
                cur_num = 4'(i);
            end
        end
    end

    assign four_n    = {25'd0, n_regs, 2'b00};
    assign mask_next = mask_q & ~(16'd1 << cur_num);

    // Addresses always ascend, so decrementing modes start at the lowest word of the block.
    always_comb begin
        unique case ({pre_index, up})
            2'b01:   start_addr = base_value;
            2'b11:   start_addr = base_value + 32'd4;
            2'b00:   start_addr = base_value - four_n + 32'd4;
            default: start_addr = base_value - four_n;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        load_d     = load_q;
        wb_d       = wb_q;
        base_reg_d = base_reg_q;
        mask_d     = mask_q;
        addr_d     = addr_q;
        new_base_d = new_base_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    load_d     = load;
                    base_reg_d = base_reg;
                    mask_d     = reg_list;
                    addr_d     = start_addr & 32'hFFFF_FFFC;
                    new_base_d = up ? (base_value + four_n) : (base_value - four_n);
                    // A loaded base register takes precedence over the writeback value.
                    wb_d       = writeback && !(load && reg_list[base_reg]);
                    state_d    = (n_regs != 5'd0) ? StXfer : StDone;
                end
            end
            StXfer: begin
                if (mem_ready) begin
                    mask_d = mask_next;
                    addr_d = addr_q + 32'd4;
                    if (mask_next == 16'd0) begin
                        state_d = wb_q ? StWb : StDone;
                    end
                end
            end
            StWb:    state_d = StDone;
            default: state_d = StIdle;
        endcase

        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StDone);
        mem_req_d   = (state_d == StXfer);
        mem_write_d = (state_d == StXfer) && !load_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            load_q      <= 1'b0;
            wb_q        <= 1'b0;
            base_reg_q  <= 4'd0;
            mask_q      <= 16'd0;
            addr_q      <= 32'd0;
            new_base_q  <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_q      <= load_d;
            wb_q        <= wb_d;
            base_reg_q  <= base_reg_d;
            mask_q      <= mask_d;
            addr_q      <= addr_d;
            new_base_q  <= new_base_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
        end
    end

    logic load_beat;
    logic wb_cycle;

    assign load_beat = mem_req_q && !mem_write_q && mem_ready;
    assign wb_cycle  = (state_q == StWb);

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_req_q ? addr_q : 32'd0;
    assign mem_wdata = (mem_req_q && mem_write_q) ? rf_read_data : 32'd0;

    assign rf_read_num   = mem_req_q ? cur_num : 4'd0;
    assign rf_write_en   = load_beat || wb_cycle;
    assign rf_write_num  = wb_cycle ? base_reg_q : (load_beat ? cur_num : 4'd0);
    assign rf_write_data = wb_cycle ? new_base_q : (load_beat ? mem_rdata : 32'd0);

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: expected beats and register writes are queued
// by each scenario and consumed by a negedge monitor.
module tb_ldm_stm_sequencer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start, load, pre_index, up, writeback;
    logic [3:0]  base_reg;
    logic [31:0] base_value;
    logic [15:0] reg_list;
    logic        busy, done, mem_req, mem_write, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  rf_read_num, rf_write_num;
    logic [31:0] rf_read_data, rf_write_data;
    logic        rf_write_en;

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] data;
    } beat_t;
    typedef struct {
        logic [3:0]  num;
        logic [31:0] data;
    } rfw_t;

    beat_t beat_q[$];
    rfw_t  rfw_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc;
    int last_rf_cyc;
    int req_seen;
    int wait_cfg = 0;
    int wait_cnt;

    always #5 clock = ~clock;

    ldm_stm_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .load          (load),
        .pre_index     (pre_index),
        .up            (up),
        .writeback     (writeback),
        .base_reg      (base_reg),
        .base_value    (base_value),
        .reg_list      (reg_list),
        .busy          (busy),
        .done          (done),
        .mem_req       (mem_req),
        .mem_write     (mem_write),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .rf_read_num   (rf_read_num),
        .rf_read_data  (rf_read_data),
        .rf_write_en   (rf_write_en),
        .rf_write_num  (rf_write_num),
        .rf_write_data (rf_write_data)
    );

    // Memory and register-file models.
    assign mem_rdata    = mem_addr ^ 32'h5A5A_0000;
    assign rf_read_data = 32'hA0 + {28'd0, rf_read_num};
    assign mem_ready    = (wait_cnt >= wait_cfg);

    always @(posedge clock or posedge reset) begin
        if (reset) wait_cnt <= 0;
        else if (mem_req && mem_ready) wait_cnt <= 0;
        else if (mem_req) wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clock) begin : monitor
        beat_t b;
        rfw_t  r;
        if (mem_req) req_seen++;
        if (mem_req && mem_ready) begin
            total++;
            if (beat_q.size() == 0) begin
                bad++;
                $display("FAIL beat_unexpected got addr=%h wr=%b", mem_addr, mem_write);
            end else begin
                b = beat_q.pop_front();
                if (mem_addr !== b.addr || mem_write !== b.wr || (b.wr && mem_wdata !== b.data)) begin
                    bad++;
                    $display("FAIL beat got addr=%h wr=%b wdata=%h want addr=%h wr=%b wdata=%h",
                             mem_addr, mem_write, mem_wdata, b.addr, b.wr, b.data);
                end
            end
        end
        if (rf_write_en) begin
            total++;
            last_rf_cyc = cyc;
            if (rfw_q.size() == 0) begin
                bad++;
                $display("FAIL rf_write_unexpected got num=%0d data=%h", rf_write_num, rf_write_data);
            end else begin
                r = rfw_q.pop_front();
                if (rf_write_num !== r.num || rf_write_data !== r.data) begin
                    bad++;
                    $display("FAIL rf_write got num=%0d data=%h want num=%0d data=%h",
                             rf_write_num, rf_write_data, r.num, r.data);
                end
            end
        end
    end

    task automatic push_beat(input logic [31:0] a, input logic wr, input logic [31:0] d);
        beat_t b;
        b.addr = a; b.wr = wr; b.data = d;
        beat_q.push_back(b);
    endtask

    task automatic push_rf(input logic [3:0] num, input logic [31:0] d);
        rfw_t r;
        r.num = num; r.data = d;
        rfw_q.push_back(r);
    endtask

    // Starts one transfer, tracks cycles relative to the start edge, and waits for done.
    task automatic run_op(input logic ld, input logic p, input logic u, input logic w,
                          input logic [3:0] br, input logic [31:0] bv, input logic [15:0] rl,
                          input int waits, input logic restart);
        @(negedge clock);
        load = ld; pre_index = p; up = u; writeback = w;
        base_reg = br; base_value = bv; reg_list = rl;
        wait_cfg = waits; done_cyc = 0; last_rf_cyc = 0; req_seen = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 1;
        for (int k = 0; k < 60 && done_cyc == 0; k++) begin
            @(negedge clock);
            if (done) begin
                done_cyc = cyc;
            end else begin
                if (restart && cyc == 1) begin
                    start = 1'b1; load = ~ld; reg_list = 16'hFFFF; base_value = 32'h0;
                end
                @(posedge clock);
                #1 start = 1'b0;
                cyc++;
            end
        end
        total++;
        if (done_cyc == 0) begin
            bad++;
            $display("FAIL done_timeout got no done want done within 60 cycles");
        end
        @(posedge clock);
        #1 cyc++;
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_done got busy=%b done=%b want 0 0", busy, done);
        end
        total++;
        if (beat_q.size() != 0 || rfw_q.size() != 0) begin
            bad++;
            $display("FAIL leftover_expect got beats=%0d rf=%0d want 0 0",
                     beat_q.size(), rfw_q.size());
        end
    endtask

    task automatic test_reset;
        #1;
        total++;
        if ({busy, done, mem_req, mem_write, mem_addr, mem_wdata, rf_read_num, rf_write_en,
             rf_write_num, rf_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got busy=%b done=%b req=%b addr=%h rfwe=%b want all 0",
                     busy, done, mem_req, mem_addr, rf_write_en);
        end
    endtask

    task automatic test_stm_ia;
        for (int i = 0; i < 4; i++) push_beat(32'h100 + 32'(4 * i), 1'b1, 32'hA0 + 32'(i));
        push_rf(4'd13, 32'h110);
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h100, 16'h000F, 0, 1'b0);
        total++;
        if (done_cyc != 6 || last_rf_cyc != 5) begin
            bad++;
            $display("FAIL stm_ia_timing got done=%0d wb=%0d want done=6 wb=5", done_cyc, last_rf_cyc);
        end
    endtask

    task automatic test_ldm_db_waits;
        push_beat(32'h1F4, 1'b0, 32'h0); push_rf(4'd0, 32'h5A5A_01F4);
        push_beat(32'h1F8, 1'b0, 32'h0); push_rf(4'd4, 32'h5A5A_01F8);
        push_beat(32'h1FC, 1'b0, 32'h0); push_rf(4'd15, 32'h5A5A_01FC);
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 32'h200, 16'h8011, 2, 1'b0);
        total++;
        if (done_cyc != 10 || last_rf_cyc != 9) begin
            bad++;
            $display("FAIL ldm_db_timing got done=%0d last_rf=%0d want done=10 last_rf=9",
                     done_cyc, last_rf_cyc);
        end
    endtask

    task automatic test_ldm_base_in_list;
        push_beat(32'h44, 1'b0, 32'h0); push_rf(4'd1, 32'h5A5A_0044);
        push_beat(32'h48, 1'b0, 32'h0); push_rf(4'd2, 32'h5A5A_0048);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 32'h40, 16'h0006, 0, 1'b0);
        total++;
        if (done_cyc != 3 || last_rf_cyc != 2) begin
            bad++;
            $display("FAIL ldm_base_in_list got done=%0d last_rf=%0d want done=3 last_rf=2",
                     done_cyc, last_rf_cyc);
        end
    endtask

    task automatic test_da_wrap;
        push_beat(32'hFFFF_FFFC, 1'b1, 32'hA0);
        push_beat(32'h0000_0000, 1'b1, 32'hA1);
        push_beat(32'h0000_0004, 1'b1, 32'hA2);
        push_rf(4'd5, 32'hFFFF_FFF8);
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 32'h4, 16'h0007, 0, 1'b0);
        total++;
        if (done_cyc != 5 || last_rf_cyc != 4) begin
            bad++;
            $display("FAIL da_wrap_timing got done=%0d wb=%0d want done=5 wb=4", done_cyc, last_rf_cyc);
        end
    endtask

    task automatic test_empty_list;
        run_op(1'b0, 1'b0, 1'b1, 1'b1, 4'd13, 32'h800, 16'h0000, 0, 1'b0);
        total++;
        if (done_cyc != 1 || req_seen != 0 || last_rf_cyc != 0) begin
            bad++;
            $display("FAIL empty_list got done=%0d reqs=%0d rf_cyc=%0d want 1 0 0",
                     done_cyc, req_seen, last_rf_cyc);
        end
    endtask

    task automatic test_start_ignored;
        push_beat(32'h500, 1'b1, 32'hA0);
        push_beat(32'h504, 1'b1, 32'hA1);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 32'h500, 16'h0003, 0, 1'b1);
        total++;
        if (done_cyc != 3) begin
            bad++;
            $display("FAIL start_ignored got done=%0d want 3", done_cyc);
        end
    endtask

    task automatic test_reset_mid_op;
        push_beat(32'h300, 1'b0, 32'h0); push_rf(4'd0, 32'h5A5A_0300);
        push_beat(32'h304, 1'b0, 32'h0); push_rf(4'd1, 32'h5A5A_0304);
        @(negedge clock);
        load = 1'b1; pre_index = 1'b0; up = 1'b1; writeback = 1'b1;
        base_reg = 4'd13; base_value = 32'h300; reg_list = 16'h000F; wait_cfg = 0;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        cyc = 1;
        @(negedge clock);
        @(posedge clock);
        #1 cyc = 2;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, done, mem_req, mem_write, mem_addr, mem_wdata, rf_read_num, rf_write_en,
             rf_write_num, rf_write_data} !== '0) begin
            bad++;
            $display("FAIL reset_mid_outputs got busy=%b req=%b addr=%h rfwe=%b want all 0",
                     busy, mem_req, mem_addr, rf_write_en);
        end
        repeat (3) @(negedge clock);
        reset = 1'b0;
        total++;
        if (beat_q.size() != 0 || rfw_q.size() != 0) begin
            bad++;
            $display("FAIL reset_mid_leftover got beats=%0d rf=%0d want 0 0",
                     beat_q.size(), rfw_q.size());
        end
        push_beat(32'h20, 1'b1, 32'hA0);
        run_op(1'b0, 1'b0, 1'b1, 1'b0, 4'd13, 32'h20, 16'h0001, 0, 1'b0);
        total++;
        if (done_cyc != 2) begin
            bad++;
            $display("FAIL restart_after_reset got done=%0d want 2", done_cyc);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; load = 1'b0; pre_index = 1'b0; up = 1'b0;
        writeback = 1'b0; base_reg = 4'd0; base_value = 32'd0; reg_list = 16'd0;
        test_reset;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        test_stm_ia;
        test_ldm_db_waits;
        test_ldm_base_in_list;
        test_da_wrap;
        test_empty_list;
        test_start_ignored;
        test_reset_mid_op;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
